uart_prog_loader: RTL and testbench

Upstream boot stage for the single-cycle RV32 core. It receives a program over a UART serial line in 8N1 format, packs the bytes into 32-bit words, and writes them sequentially into the instruction memory's write port. While a load is in progress it holds the CPU in reset through cpu_hold. After the last word is written it releases the CPU so execution starts at PC 0.

---
 rtl/uart_prog_loader.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
`timescale 1ns/1ps
// uart_prog_loader: receives a program over 8N1 UART, packs bytes little-endian
// into 32-bit words and writes them sequentially into instruction memory. The
// CPU is held in reset while a load is in progress or after a failed load.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 6,
  parameter int WORDS        = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              start_load,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------------------
  // rx synchronizer and edge history (idle level is high)
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------------------------------------------------------------------
  // RX byte engine
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  // RX state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= {CNT_W{1'b0}};
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'h00;
      rx_byte_q    <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // RX next state: start bit checked at half period, data/stop at bit centres.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = {CNT_W{1'b0}};
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d = {CNT_W{1'b0}};
          rx_bit_d = 3'd0;
          if (!rx_sync_q) begin
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;  // glitch: silently drop
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == LAST_CNT) begin
          rx_cnt_d   = {CNT_W{1'b0}};
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};  // LSB first
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == LAST_CNT) begin
          rx_cnt_d   = {CNT_W{1'b0}};
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            rx_byte_d    = rx_shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load controller
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [31:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= {(ADDR_W+1){1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      wc_q    <= {(ADDR_W+1){1'b0}};
      bidx_q  <= 2'd0;
      word_q  <= 32'h0000_0000;
      we_q    <= 1'b0;
      waddr_q <= {ADDR_W{1'b0}};
      wdata_q <= 32'h0000_0000;
      busy_q  <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Controller next state; status flags are derived from the next state so
  // they change together with the state register.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wc_d    = wc_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_load) begin
          state_d = S_LEN;
          len_d   = {(ADDR_W+1){1'b0}};
          addr_d  = {ADDR_W{1'b0}};
          wc_d    = {(ADDR_W+1){1'b0}};
          bidx_d  = 2'd0;
          word_d  = 32'h0000_0000;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN: begin
        if (frame_err_q) begin
          state_d = S_ERR;
        end else if (byte_valid_q) begin
          if (rx_byte_q == 8'h00) begin
            state_d = S_DONE;
          end else if (32'(rx_byte_q) > 32'(WORDS)) begin
            state_d = S_ERR;
          end else begin
            len_d   = (ADDR_W+1)'(rx_byte_q);
            bidx_d  = 2'd0;
            state_d = S_DATA;
          end
        end else begin
          state_d = S_LEN;
        end
      end
      S_DATA: begin
        if (frame_err_q) begin
          state_d = S_ERR;
        end else if (byte_valid_q) begin
          // Shift in from the top: after four bytes byte 0 sits in [7:0].
          word_d = {rx_byte_q, word_q[31:8]};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = {rx_byte_q, word_q[31:8]};
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        wc_d   = wc_q + (ADDR_W+1)'(1);
        if ((wc_q + (ADDR_W+1)'(1)) == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE);
    hold_d = busy_d || (state_d == S_ERR);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
`timescale 1ns/1ps
// Directed self-checking bench for uart_prog_loader (CLKS_PER_BIT = 4).
module tb_uart_prog_loader;

  localparam int CPB    = 4;
  localparam int ADDR_W = 6;
  localparam int WORDS  = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rx = 1'b1;
  logic              start_load = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (ADDR_W),
    .WORDS       (WORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .start_load(start_load),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  wire [49:0] outs = {imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err, word_count};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write-strobe log, sampled on the falling edge.
  int                we_cnt = 0;
  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      we_cnt++;
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
  endtask

  task automatic wait_not_busy(input string tag);
    int c;
    c = 0;
    while (busy === 1'b1 && c < 500) begin
      @(negedge clk);
      c++;
    end
    check_val(tag, 64'(c >= 500), 64'h0);
  endtask

  logic [7:0] prog1 [9] = '{8'h02, 8'h13, 8'h05, 8'h50, 8'h00, 8'hB3, 8'h02, 8'h52, 8'h00};
  int  base;
  bit  bad;

  initial begin
    // Reset and quiet idle
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_outs", 64'(outs), 64'h0);
    rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (outs !== 50'h0) bad = 1'b1;
    end
    check_val("idle_quiet", 64'(bad), 64'h0);
    check_val("idle_no_we", 64'(we_cnt), 64'h0);

    // Normal two-word load
    pulse_start();
    check_val("arm_busy", 64'(busy), 64'h1);
    check_val("arm_hold", 64'(cpu_hold), 64'h1);
    for (int i = 0; i < 9; i++) send_byte(prog1[i], 1'b1);
    wait_not_busy("load_timeout");
    check_val("load_we_cnt", 64'(we_cnt), 64'd2);
    check_val("load_a0", 64'(log_addr[0]), 64'd0);
    check_val("load_d0", 64'(log_data[0]), 64'h0050_0513);
    check_val("load_a1", 64'(log_addr[1]), 64'd1);
    check_val("load_d1", 64'(log_data[1]), 64'h0052_02B3);
    check_val("load_done", 64'(done), 64'h1);
    check_val("load_hold", 64'(cpu_hold), 64'h0);
    check_val("load_wc", 64'(word_count), 64'd2);
    check_val("load_err", 64'(err), 64'h0);
    check_val("hold_addr", 64'(imem_addr), 64'd1);
    check_val("hold_data", 64'(imem_wdata), 64'h0052_02B3);

    // Framing error then retry
    base = we_cnt;
    pulse_start();
    send_byte(8'h01, 1'b1);
    send_byte(8'hAA, 1'b0);
    check_val("ferr_err", 64'(err), 64'h1);
    check_val("ferr_busy", 64'(busy), 64'h0);
    check_val("ferr_hold", 64'(cpu_hold), 64'h1);
    check_val("ferr_done", 64'(done), 64'h0);
    check_val("ferr_no_we", 64'(we_cnt), 64'(base));
    pulse_start();
    check_val("retry_err_clr", 64'(err), 64'h0);
    check_val("retry_busy", 64'(busy), 64'h1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    wait_not_busy("retry_timeout");
    check_val("retry_done", 64'(done), 64'h1);
    check_val("retry_err", 64'(err), 64'h0);
    check_val("retry_we_cnt", 64'(we_cnt), 64'(base + 1));
    check_val("retry_a0", 64'(log_addr[base]), 64'd0);
    check_val("retry_d0", 64'(log_data[base]), 64'h1234_5678);

    // Length error (65 > WORDS)
    base = we_cnt;
    pulse_start();
    send_byte(8'h41, 1'b1);
    check_val("len_err", 64'(err), 64'h1);
    check_val("len_busy", 64'(busy), 64'h0);
    check_val("len_hold", 64'(cpu_hold), 64'h1);
    check_val("len_no_we", 64'(we_cnt), 64'(base));
    check_val("len_wc", 64'(word_count), 64'd0);

    // Glitch rejection and start_load ignored while busy
    base = we_cnt;
    pulse_start();
    send_byte(8'h02, 1'b1);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    check_val("glitch_err", 64'(err), 64'h0);
    check_val("glitch_busy", 64'(busy), 64'h1);
    send_byte(8'h11, 1'b1);
    pulse_start();
    check_val("ign_wc0", 64'(word_count), 64'd0);
    check_val("ign_busy0", 64'(busy), 64'h1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check_val("glitch_wc1", 64'(word_count), 64'd1);
    check_val("glitch_a0", 64'(log_addr[base]), 64'd0);
    check_val("glitch_d0", 64'(log_data[base]), 64'h4433_2211);
    pulse_start();
    check_val("ign_wc1", 64'(word_count), 64'd1);
    check_val("ign_addr", 64'(imem_addr), 64'd0);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    wait_not_busy("glitch_timeout");
    check_val("glitch_done", 64'(done), 64'h1);
    check_val("glitch_wc2", 64'(word_count), 64'd2);
    check_val("glitch_we_cnt", 64'(we_cnt), 64'(base + 2));
    check_val("glitch_a1", 64'(log_addr[base + 1]), 64'd1);
    check_val("glitch_d1", 64'(log_data[base + 1]), 64'h8877_6655);

    // Reset in the middle of a two-word load
    base = we_cnt;
    pulse_start();
    send_byte(8'h02, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("midrst_outs", 64'(outs), 64'h0);
    check_val("midrst_we_cnt", 64'(we_cnt), 64'(base + 1));
    check_val("midrst_a0", 64'(log_addr[base]), 64'd0);
    check_val("midrst_d0", 64'(log_data[base]), 64'hDEAD_BEEF);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check_val("postrst_outs", 64'(outs), 64'h0);
    check_val("postrst_no_a1", 64'(we_cnt), 64'(base + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
